// File: rtl/execute_pipe.sv
// -----------------------------------------------------------------------------
// execute_pipe -- execute stage of a simple pipelined datapath.
//
// Takes one operation per valid/ready handshake, computes the ALU result, the
// branch target (PC + imm*4) and the store data, and presents them in an
// output register with its own valid/ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid may not see its data
// taken until that edge. The output register holds its contents and out_valid
// steady while out_valid && !out_ready.
//
// Optional feature: define EXECUTE_MUL_EN to build an iterative shift-add
// multiplier for AluControl 4'b1000 (low N bits of A*B, N iteration cycles).
// Without it, 4'b1000 is an undefined code (result 0, latency 1) and busy is 0.
//
// Parameters:
//   N            datapath width in bits (N >= 8)
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   in_valid     upstream operation valid
//   in_ready     stage can accept an operation this edge
//   AluSrc       operand B select (1 = signImm_E, 0 = readData2_E)
//   AluControl   operation code
//   PC_E         program counter of the operation
//   signImm_E    sign-extended immediate
//   readData1_E  register operand A
//   readData2_E  register operand B / store data
//   out_valid    result register valid
//   out_ready    downstream accepts the result
//   PCBranch_E   registered branch target
//   aluResult_E  registered ALU result
//   writeData_E  registered store data
//   zero_E       registered (aluResult_E == 0)
//   busy         multiply in progress (FSM in MUL)
// -----------------------------------------------------------------------------
module execute_pipe #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic         busy
);

  logic         fire;
  logic [N-1:0] op_b;
  logic [N-1:0] alu_res;
  logic [N-1:0] pc_target;

  assign fire      = in_valid && in_ready;
  assign op_b      = AluSrc ? signImm_E : readData2_E;
  assign pc_target = PC_E + (signImm_E << 2);

  // Single-cycle ALU. Code 4'b1000 is never produced here: when the
  // multiplier is built it is handled by the FSM, otherwise it is undefined.
  always_comb begin
    alu_res = '0;
    case (AluControl)
      4'b0000: alu_res = readData1_E & op_b;
      4'b0001: alu_res = readData1_E | op_b;
      4'b0010: alu_res = readData1_E + op_b;
      4'b0110: alu_res = readData1_E - op_b;
      4'b0111: alu_res = op_b;
      4'b1100: alu_res = ~(readData1_E | op_b);
      default: alu_res = '0;
    endcase
  end

`ifdef EXECUTE_MUL_EN

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  mul_acc;
  logic [N-1:0]  mul_mcand;
  logic [N-1:0]  mul_mplier;
  logic [CW-1:0] mul_count;
  logic [N-1:0]  pend_pc;
  logic [N-1:0]  pend_wd;
  logic [N-1:0]  mul_next;
  logic          mul_start;

  assign mul_start = fire && (AluControl == 4'b1000);
  // One shift-add step: add the (already shifted) multiplicand when the
  // current low multiplier bit is set. Bits shifted past N are dropped, which
  // gives exactly the low N bits of the product.
  assign mul_next  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  assign busy     = (state == MUL);
  assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      PCBranch_E  <= '0;
      aluResult_E <= '0;
      writeData_E <= '0;
      zero_E      <= 1'b1;
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
      mul_count   <= '0;
      pend_pc     <= '0;
      pend_wd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            // Any result being drained this edge leaves; the product
            // appears only after the last iteration.
            state      <= MUL;
            out_valid  <= 1'b0;
            mul_acc    <= '0;
            mul_mcand  <= readData1_E;
            mul_mplier <= op_b;
            mul_count  <= '0;
            pend_pc    <= pc_target;
            pend_wd    <= readData2_E;
          end else if (fire) begin
            out_valid   <= 1'b1;
            aluResult_E <= alu_res;
            zero_E      <= (alu_res == '0);
            PCBranch_E  <= pc_target;
            writeData_E <= readData2_E;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          mul_acc    <= mul_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_count  <= mul_count + 1'b1;
          if (mul_count == MUL_LAST) begin
            state       <= IDLE;
            out_valid   <= 1'b1;
            aluResult_E <= mul_next;
            zero_E      <= (mul_next == '0);
            PCBranch_E  <= pend_pc;
            writeData_E <= pend_wd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign busy     = 1'b0;
  assign in_ready = !reset && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      PCBranch_E  <= '0;
      aluResult_E <= '0;
      writeData_E <= '0;
      zero_E      <= 1'b1;
    end else if (fire) begin
      out_valid   <= 1'b1;
      aluResult_E <= alu_res;
      zero_E      <= (alu_res == '0);
      PCBranch_E  <= pc_target;
      writeData_E <= readData2_E;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_execute_pipe.sv
// -----------------------------------------------------------------------------
// tb_execute_pipe -- self-checking bench for execute_pipe (N = 64).
// Directed scenarios plus a randomized run scored against a queue-based
// reference model. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_execute_pipe;

  localparam int N = 64;
  localparam int W = 3 * N + 1;

`ifdef EXECUTE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         AluSrc = 1'b0;
  logic [3:0]   AluControl = 4'b0;
  logic [N-1:0] PC_E = '0;
  logic [N-1:0] signImm_E = '0;
  logic [N-1:0] readData1_E = '0;
  logic [N-1:0] readData2_E = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] PCBranch_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] writeData_E;
  logic         zero_E;
  logic         busy;

  always #5 clk = ~clk;

  execute_pipe #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .zero_E      (zero_E),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];

  function automatic logic [N-1:0] ref_alu(input logic [3:0] ctl,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    logic [N-1:0] r;
    case (ctl)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = b;
      4'd12:   r = ~(a | b);
      4'd8:    r = MUL_EN ? a * b : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [3:0] ctl, input logic src,
                                              input logic [N-1:0] pc, input logic [N-1:0] imm,
                                              input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] res;
    logic [N-1:0] tgt;
    res = ref_alu(ctl, a, src ? imm : b);
    tgt = pc + imm * 4;
    return {(res == '0), b, tgt, res};
  endfunction

  function automatic logic [N-1:0] rand_val();
    logic [N-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = N'($urandom_range(0, 7));
      1:       v = {$urandom, $urandom};
      2:       v = '1;
      default: v = N'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [3:0] ctl, input logic src, input logic [N-1:0] pc,
                        input logic [N-1:0] imm, input logic [N-1:0] a, input logic [N-1:0] b);
    AluControl  = ctl;
    AluSrc      = src;
    PC_E        = pc;
    signImm_E   = imm;
    readData1_E = a;
    readData2_E = b;
  endtask

  // Presents an op and returns 1 time unit after the edge that accepted it.
  task automatic issue_op(input logic [3:0] ctl, input logic src, input logic [N-1:0] pc,
                          input logic [N-1:0] imm, input logic [N-1:0] a, input logic [N-1:0] b);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    set_op(ctl, src, pc, imm, a, b);
    in_valid = 1'b1;
    while (!done && waited < 300) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_op_accept: in_ready never high within %0d cycles", waited);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready, zero_E} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags: got valid/busy/ready/zero=%b required 0001",
               {out_valid, busy, in_ready, zero_E});
    end
    checks++;
    if ({aluResult_E, PCBranch_E, writeData_E} !== '0) begin
      errors++;
      $display("FAIL reset_data: got alu=%h pcb=%h wd=%h required 0", aluResult_E, PCBranch_E,
               writeData_E);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got ready/valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    issue_op(4'b0010, 1'b1, 64'h100, 64'd3, 64'd5, 64'h55);
    @(negedge clk);
    checks++;
    if ({out_valid, aluResult_E, PCBranch_E, writeData_E, zero_E} !==
        {1'b1, 64'd8, 64'h10C, 64'h55, 1'b0}) begin
      errors++;
      $display("FAIL add: got v=%b alu=%h pcb=%h wd=%h z=%b required v=1 alu=8 pcb=10c wd=55 z=0",
               out_valid, aluResult_E, PCBranch_E, writeData_E, zero_E);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_sub_zero();
    out_ready = 1'b1;
    issue_op(4'b0110, 1'b0, 64'h40, 64'h9, 64'd7, 64'd7);
    @(negedge clk);
    checks++;
    if ({out_valid, aluResult_E, zero_E, writeData_E} !== {1'b1, 64'd0, 1'b1, 64'd7}) begin
      errors++;
      $display("FAIL sub_zero: got v=%b alu=%h z=%b wd=%h required v=1 alu=0 z=1 wd=7",
               out_valid, aluResult_E, zero_E, writeData_E);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    issue_op(4'b0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'h10, 64'h0);
    @(negedge clk);
    checks++;
    if ({out_valid, PCBranch_E, aluResult_E} !== {1'b1, 64'h0, 64'h11}) begin
      errors++;
      $display("FAIL wrap: got v=%b pcb=%h alu=%h required v=1 pcb=0 alu=11",
               out_valid, PCBranch_E, aluResult_E);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue_op(4'b0010, 1'b0, 64'h200, 64'h1, 64'd1, 64'd2);
    // Second op waits while the first result is stalled.
    set_op(4'b0110, 1'b0, 64'h300, 64'h2, 64'd10, 64'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, aluResult_E, PCBranch_E} !== {1'b0, 1'b1, 64'd3, 64'h204}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b alu=%h pcb=%h required rdy=0 v=1 alu=3 pcb=204",
                 i, in_ready, out_valid, aluResult_E, PCBranch_E);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release_ready: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, aluResult_E, PCBranch_E} !== {1'b1, 64'd6, 64'h308}) begin
      errors++;
      $display("FAIL backpressure_second: got v=%b alu=%h pcb=%h required v=1 alu=6 pcb=308",
               out_valid, aluResult_E, PCBranch_E);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_mul();
    int bad_busy;
    bad_busy = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue_op(4'b1000, 1'b0, 64'h0, 64'h0, 64'hFFFF_FFFF, 64'd3);
    if (MUL_EN) begin
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
          errors++;
          bad_busy++;
          if (bad_busy < 5)
            $display("FAIL mul_busy[%0d]: got busy/ready/valid=%b required 100", i,
                     {busy, in_ready, out_valid});
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, aluResult_E} !== {1'b1, 1'b0, (MUL_EN ? 64'h2_FFFF_FFFD : 64'h0)}) begin
      errors++;
      $display("FAIL mul_result: got v=%b busy=%b alu=%h required v=1 busy=0 alu=%h",
               out_valid, busy, aluResult_E, (MUL_EN ? 64'h2_FFFF_FFFD : 64'h0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int stray;
    stray = 0;
    out_ready = 1'b1;
    issue_op(4'b1000, 1'b1, 64'h0, 64'd5, 64'h1234, 64'h0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_mul: got valid/busy/ready=%b required 001",
               {out_valid, busy, in_ready});
    end
    for (int i = 0; i < N + 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_mul_no_result: got %0d valid cycles required 0", stray);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic [W:0]   held;
    bit           hold_pending;
    int           done_cnt;
    hold_pending = 1'b0;
    done_cnt     = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rand_val(), rand_val(),
             rand_val(), rand_val());
      @(negedge clk);
      got = {zero_E, writeData_E, PCBranch_E, aluResult_E};
      if (hold_pending) begin
        checks++;
        if ({out_valid, got} !== held) begin
          errors++;
          $display("FAIL random_hold: got %h required %h", {out_valid, got}, held);
        end
      end
      hold_pending = out_valid && !out_ready;
      held = {1'b1, got};
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_unexpected: result %h with empty model queue", got);
        end else begin
          exp = exp_q.pop_front();
          done_cnt++;
          if (got !== exp) begin
            errors++;
            $display("FAIL random_result: got %h required %h", got, exp);
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_result(AluControl, AluSrc, PC_E, signImm_E, readData1_E,
                                   readData2_E));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = {zero_E, writeData_E, PCBranch_E, aluResult_E};
        exp = exp_q.pop_front();
        done_cnt++;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random_drain: got %h required %h", got, exp);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_cnt < 100) begin
      errors++;
      $display("FAIL random_complete: got %0d pending, %0d completed required 0 pending, >=100 completed",
               exp_q.size(), done_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_wrap();
    test_backpressure();
    test_mul();
    test_reset_mid_mul();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
